// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver
//   Drives one H-bridge channel from the signed PID controller output.
//   The command magnitude, saturated to PERIOD, becomes the PWM duty and its
//   sign becomes the direction. New commands are taken only at period
//   boundaries. Both legs are held low for DEADTIME cycles on enable and on
//   every direction reversal.
//
//   Optional build macro: PWM_SLEW_LIMIT_EN
//     When it is defined, the signed applied command moves toward the target by
//     at most SLEW_STEP per period. A reversal therefore ramps through zero.
//     When it is undefined, the saturated command is applied directly.
//
// Ports
//   clock           system clock
//   reset_n         asynchronous active-low reset
//   i_command[31:0] signed duty command
//   i_enable        run request; low forces the bridge off
//   o_pwm_a         forward leg drive
//   o_pwm_b         reverse leg drive
//   o_dir           applied direction (0 = forward, 1 = reverse)
//   o_duty          applied magnitude, 0..PERIOD
//   o_period_start  pulse in the first cycle of each RUN period
//   o_active        high while in RUN
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | bridge off, waiting for i_enable
// ST_DEAD | both legs low, dead-time down-counter running
// ST_RUN  | PWM active, period counter 0..PERIOD-1

module motor_pwm_driver #(
  parameter int PERIOD    = 4000,
  parameter int CNT_W     = 16,
  parameter int DEADTIME  = 10,
  parameter int SLEW_STEP = 100
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      i_command,
  input  logic             i_enable,
  output logic             o_pwm_a,
  output logic             o_pwm_b,
  output logic             o_dir,
  output logic [CNT_W-1:0] o_duty,
  output logic             o_period_start,
  output logic             o_active
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PERIOD_C    = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] LAST_C      = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DEAD_LOAD_C = CNT_W'(DEADTIME - 1);

  // Elaboration-time guard on the parameter set.
  if (PERIOD < 1 || DEADTIME < 1 || SLEW_STEP < 1 ||
      PERIOD >= (1 << CNT_W) || DEADTIME > (1 << CNT_W)) begin : g_param_check
    $error("motor_pwm_driver: illegal parameter combination");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dead_q, dead_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             pwm_a_q, pwm_a_d;
  logic             pwm_b_q, pwm_b_d;
  logic             pstart_q, pstart_d;
  logic             active_q, active_d;

  // Value that the next sample point would apply.
  logic [CNT_W-1:0] smp_mag;
  logic             smp_sign;
  logic             smp_nz;

`ifdef PWM_SLEW_LIMIT_EN
  // The applied command is signed. The extra headroom bits hold target - applied,
  // which can reach 2*PERIOD.
  localparam int AW = CNT_W + 2;
  localparam logic signed [31:0]   PERIOD_S = 32'(PERIOD);
  localparam logic signed [AW-1:0] SLEW_S   = AW'(SLEW_STEP);

  logic signed [AW-1:0] applied_q, applied_d;
  logic signed [AW-1:0] applied_nx;
  logic signed [AW-1:0] target_s;
  logic signed [AW-1:0] diff_s;
  logic signed [AW-1:0] step_s;
  logic signed [31:0]   cmd_s;

  always_comb begin
    cmd_s = i_command;
    if (cmd_s > PERIOD_S) begin
      target_s = AW'(PERIOD);
    end else if (cmd_s < -PERIOD_S) begin
      target_s = -AW'(PERIOD);
    end else begin
      target_s = AW'(cmd_s);
    end
    diff_s = target_s - applied_q;
    if (diff_s > SLEW_S) begin
      step_s = SLEW_S;
    end else if (diff_s < -SLEW_S) begin
      step_s = -SLEW_S;
    end else begin
      step_s = diff_s;
    end
    applied_nx = applied_q + step_s;
    smp_sign   = applied_nx[AW-1];
    smp_nz     = (applied_nx != '0);
    smp_mag    = CNT_W'((applied_nx < 0) ? -applied_nx : applied_nx);
  end
`else
  // 33 bits keep the magnitude of -2^31 representable, so it saturates and
  // does not wrap.
  logic [32:0] cmd_abs;

  always_comb begin
    cmd_abs  = i_command[31] ? (33'd0 - {1'b1, i_command}) : {1'b0, i_command};
    smp_mag  = (cmd_abs > 33'(PERIOD)) ? PERIOD_C : cmd_abs[CNT_W-1:0];
    smp_sign = i_command[31];
    smp_nz   = (smp_mag != '0);
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dead_d  = dead_q;
    dir_d   = dir_q;
    duty_d  = duty_q;
`ifdef PWM_SLEW_LIMIT_EN
    applied_d = applied_q;
`endif

    if (!i_enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      dead_d  = '0;
      dir_d   = 1'b0;
      duty_d  = '0;
`ifdef PWM_SLEW_LIMIT_EN
      applied_d = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_DEAD;
          dead_d  = DEAD_LOAD_C;
          cnt_d   = '0;
          duty_d  = smp_mag;
          if (smp_nz) dir_d = smp_sign;
`ifdef PWM_SLEW_LIMIT_EN
          applied_d = applied_nx;
`endif
        end
        ST_DEAD: begin
          if (dead_q == '0) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            dead_d = dead_q - 1'b1;
          end
        end
        ST_RUN: begin
          if (cnt_q == LAST_C) begin
            cnt_d  = '0;
            duty_d = smp_mag;
`ifdef PWM_SLEW_LIMIT_EN
            applied_d = applied_nx;
`endif
            // A zero command keeps the old direction and never reverses.
            if (smp_nz) begin
              dir_d = smp_sign;
              if (smp_sign != dir_q) begin
                state_d = ST_DEAD;
                dead_d  = DEAD_LOAD_C;
              end
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // The outputs are taken from the next-state values. They are registered,
    // and they line up with the state and counter in the same cycle.
    active_d = (state_d == ST_RUN);
    pstart_d = active_d && (cnt_d == '0);
    pwm_a_d  = active_d && !dir_d && (cnt_d < duty_d);
    pwm_b_d  = active_d &&  dir_d && (cnt_d < duty_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dead_q   <= '0;
      dir_q    <= 1'b0;
      duty_q   <= '0;
      pwm_a_q  <= 1'b0;
      pwm_b_q  <= 1'b0;
      pstart_q <= 1'b0;
      active_q <= 1'b0;
`ifdef PWM_SLEW_LIMIT_EN
      applied_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dead_q   <= dead_d;
      dir_q    <= dir_d;
      duty_q   <= duty_d;
      pwm_a_q  <= pwm_a_d;
      pwm_b_q  <= pwm_b_d;
      pstart_q <= pstart_d;
      active_q <= active_d;
`ifdef PWM_SLEW_LIMIT_EN
      applied_q <= applied_d;
`endif
    end
  end

  assign o_pwm_a        = pwm_a_q;
  assign o_pwm_b        = pwm_b_q;
  assign o_dir          = dir_q;
  assign o_duty         = duty_q;
  assign o_period_start = pstart_q;
  assign o_active       = active_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver with PERIOD=100, DEADTIME=4 and SLEW_STEP=10.
// Inputs are driven on the falling edge, and the outputs are compared on the
// falling edge.
module tb_motor_pwm_driver;
  localparam int P  = 100;
  localparam int CW = 16;
  localparam int DT = 4;
  localparam int SS = 10;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               i_enable = 1'b0;
  logic signed [31:0] i_command = 32'sd0;
  logic               o_pwm_a, o_pwm_b, o_dir, o_period_start, o_active;
  logic [CW-1:0]      o_duty;

  int n_cmp = 0;
  int n_bad = 0;

  motor_pwm_driver #(.PERIOD(P), .CNT_W(CW), .DEADTIME(DT), .SLEW_STEP(SS)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .i_command      (i_command),
    .i_enable       (i_enable),
    .o_pwm_a        (o_pwm_a),
    .o_pwm_b        (o_pwm_b),
    .o_dir          (o_dir),
    .o_duty         (o_duty),
    .o_period_start (o_period_start),
    .o_active       (o_active)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. The bridge is either off, counting down dead cycles, or
  // running at some position within the period. m_pos is -1 when the bridge is
  // not running.
  bit     m_on;
  int     m_dead;
  int     m_pos;
  bit     m_dir;
  int     m_duty;
  longint m_app;

  function automatic bit m_sample();
    longint t, d;
    bit     rev;
    t = i_command;
    if (t > P)  t = P;
    if (t < -P) t = -P;
`ifdef PWM_SLEW_LIMIT_EN
    d = t - m_app;
    if (d > SS)  d = SS;
    if (d < -SS) d = -SS;
    m_app = m_app + d;
`else
    d = 0;
    m_app = t + d;
`endif
    rev = 1'b0;
    if (m_app != 0) begin
      rev   = ((m_app < 0) != m_dir);
      m_dir = (m_app < 0);
    end
    m_duty = int'((m_app < 0) ? -m_app : m_app);
    return rev;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n || !i_enable) begin
      m_on = 0; m_dead = 0; m_pos = -1; m_dir = 0; m_duty = 0; m_app = 0;
    end else if (!m_on) begin
      m_on = 1;
      void'(m_sample());
      m_dead = DT;
      m_pos  = -1;
    end else if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) m_pos = 0;
    end else if (m_pos == P - 1) begin
      if (m_sample()) begin
        m_dead = DT;
        m_pos  = -1;
      end else begin
        m_pos = 0;
      end
    end else begin
      m_pos++;
    end
  end

  always @(negedge clock) begin
    check("m_pwm_a",  o_pwm_a,        (m_pos >= 0) && !m_dir && (m_pos < m_duty));
    check("m_pwm_b",  o_pwm_b,        (m_pos >= 0) &&  m_dir && (m_pos < m_duty));
    check("m_dir",    o_dir,          m_dir);
    check("m_duty",   o_duty,         m_duty);
    check("m_pstart", o_period_start, m_pos == 0);
    check("m_active", o_active,       m_pos >= 0);
    check("ab_excl",  o_pwm_a & o_pwm_b, 0);
  end

  // Returns at the next falling edge with o_period_start high. n is the
  // number of falling edges that elapsed.
  task automatic wait_pstart(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clock);
      n++;
      if (o_period_start) return;
    end
    check("pstart_timeout", 0, 1);
  endtask

  // Counts the high cycles of each leg over one period, starting at a pstart edge.
  task automatic measure(output int na, output int nb);
    na = 0; nb = 0;
    for (int i = 0; i < P; i++) begin
      na += int'(o_pwm_a);
      nb += int'(o_pwm_b);
      @(negedge clock);
    end
  endtask

`ifdef PWM_SLEW_LIMIT_EN
  int exp6[4] = '{10, 20, 30, 35};
`endif

  initial begin
    int n, na, nb;
    repeat (3) @(negedge clock);
    check("rst_duty",   o_duty, 0);
    check("rst_active", o_active, 0);
    check("rst_bits",   {o_pwm_a, o_pwm_b, o_dir, o_period_start}, 0);
    reset_n = 1'b1;
    @(negedge clock);

`ifdef PWM_SLEW_LIMIT_EN
    i_enable = 1'b1; i_command = 32'sd0;
    wait_pstart(20, n);
    i_command = 32'sd35;
    for (int k = 0; k < 4; k++) begin
      wait_pstart(300, n);
      check("t6_slew_duty", o_duty, exp6[k]);
    end
    i_command = 32'sd40;
    wait_pstart(300, n);
    wait_pstart(300, n);
`else
    i_enable = 1'b1; i_command = 32'sd40;
    wait_pstart(20, n);
    check("t1_enable_lat", n, 5);
`endif
    measure(na, nb);
`ifndef PWM_SLEW_LIMIT_EN
    check("t1_a_high", na, 40);
    check("t1_b_high", nb, 0);
    check("t1_period", o_period_start, 1);
`endif

    repeat (30) @(negedge clock);
    i_command = -32'sd70;
    wait_pstart(300, n);
`ifndef PWM_SLEW_LIMIT_EN
    check("t2_rev_gap", n, 74);
    check("t2_dir", o_dir, 1);
`endif
    measure(na, nb);
`ifndef PWM_SLEW_LIMIT_EN
    check("t2_b_high", nb, 70);
    check("t2_a_high", na, 0);
`endif

    i_command = 32'sd5000;
    wait_pstart(300, n);
`ifndef PWM_SLEW_LIMIT_EN
    check("t3_rev_gap", n, 104);
    check("t3_sat_duty", o_duty, 100);
`endif
    measure(na, nb);
`ifndef PWM_SLEW_LIMIT_EN
    check("t3_a_full", na, 100);
`endif
    i_command = 32'sh8000_0000;
    wait_pstart(300, n);
`ifndef PWM_SLEW_LIMIT_EN
    check("t3_min_gap", n, 104);
    check("t3_min_duty", o_duty, 100);
    check("t3_min_dir", o_dir, 1);
`endif
    measure(na, nb);
`ifndef PWM_SLEW_LIMIT_EN
    check("t3_b_full", nb, 100);
`endif

    i_command = -32'sd30;
    wait_pstart(300, n);
    measure(na, nb);
`ifndef PWM_SLEW_LIMIT_EN
    check("t4_b_30", nb, 30);
`endif
    i_command = 32'sd0;
    wait_pstart(300, n);
`ifndef PWM_SLEW_LIMIT_EN
    check("t4_zero_len", n, 100);
    check("t4_zero_duty", o_duty, 0);
    check("t4_zero_dir", o_dir, 1);
`endif
    measure(na, nb);
`ifndef PWM_SLEW_LIMIT_EN
    check("t4_zero_legs", na + nb, 0);
    check("t4_period", o_period_start, 1);
`endif

    i_command = -32'sd50;
    wait_pstart(300, n);
    repeat (10) @(negedge clock);
`ifndef PWM_SLEW_LIMIT_EN
    check("t5_b_high", o_pwm_b, 1);
`endif
    i_enable = 1'b0;
    @(negedge clock);
    check("t5_off_legs", {o_pwm_a, o_pwm_b}, 0);
    check("t5_off_active", o_active, 0);
    i_enable = 1'b1;
    wait_pstart(20, n);
    check("t5_reenable_lat", n, 5);
    repeat (5) @(negedge clock);
`ifndef PWM_SLEW_LIMIT_EN
    check("t5_b_before_rst", o_pwm_b, 1);
`endif
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_rst", {o_pwm_a, o_pwm_b, o_dir, o_period_start, o_active}, 0);
    check("t5_async_duty", o_duty, 0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_pstart(20, n);
    check("t5_resume_lat", n, 5);
    measure(na, nb);
`ifndef PWM_SLEW_LIMIT_EN
    check("t5_resume_b", nb, 50);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
- Downstream stage of the PID controller: consumes the signed 32-bit controller output and drives one H-bridge motor channel.
- Converts the signed command into a fixed-period PWM duty (magnitude) plus a direction bit.
- Commands are applied only at period boundaries, so a running period is never corrupted.
- Dead time is inserted on every direction reversal and on enable, so both bridge legs are never driven at once.

Parameters:
- PERIOD, 4000: PWM period in clock cycles; full-scale magnitude, matches the controller's default ±4000 output clamp.
- CNT_W, 16: width of the period counter and the duty register; must hold PERIOD.
- DEADTIME, 10: cycles with both legs low before driving after a reversal or enable; must be ≥1.
- SLEW_STEP, 100: maximum change of the signed applied command per period; used only with PWM_SLEW_LIMIT_EN.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- i_command  in  32  signed duty command (PID o_output)
- i_enable  in  1  run request; low forces the bridge off
- o_pwm_a  out  1  forward leg drive
- o_pwm_b  out  1  reverse leg drive
- o_dir  out  1  applied direction (0 = forward/positive, 1 = reverse)
- o_duty  out  CNT_W  applied magnitude, 0..PERIOD
- o_period_start  out  1  one-cycle pulse in the first cycle of each RUN period
- o_active  out  1  high in RUN

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n low, immediate, clock-independent):
  - state=IDLE, counter=0.
  - o_pwm_a, o_pwm_b, o_dir, o_duty, o_period_start and o_active all 0.
  - Deassertion is sampled synchronously.
- States:
  - IDLE: both legs low.
  - DEAD: both legs low, dead-time counter running.
  - RUN: PWM active.
- Command sampling:
  - Sampled at the "sample point": the cycle RUN has counter==PERIOD-1, or the cycle IDLE sees i_enable high.
  - mag = |i_command| saturated to PERIOD. i_command = -2^31 gives mag=PERIOD; no overflow wrap.
  - sign = i_command[31].
  - If mag==0: duty=0 and o_dir holds its previous value; a zero command never causes a reversal.
- Transitions:
  - IDLE -> DEAD when i_enable=1. The command is latched on that edge and o_dir/o_duty update on it.
  - DEAD -> RUN after exactly DEADTIME cycles in DEAD; counter=0 on RUN entry.
  - RUN at the sample point:
    - If mag≠0 and sign≠o_dir: go to DEAD. The new dir/duty latch on that edge, so the period is stretched by DEADTIME.
    - Otherwise counter wraps to 0 and the new duty applies from that edge. No gap in the PWM.
  - Any state -> IDLE on the edge where i_enable=0. Outputs are low from that edge; counter=0.
- Counter: counts 0..PERIOD-1 in RUN and holds 0 elsewhere.
- Outputs (all registered, changing only on clock edges):
  - o_pwm_a = RUN & ~o_dir & (counter < o_duty).
  - o_pwm_b = RUN & o_dir & (counter < o_duty).
  - Net result: the active leg is high exactly o_duty cycles per period.
  - duty=PERIOD gives the active leg continuously high; duty=0 gives continuously low.
- o_period_start is high in the cycle counter==0 in RUN.
- Invariant: o_pwm_a & o_pwm_b is never 1.
- Latency: a command present at the sample point drives the legs from the next cycle. A command change between sample points has no effect.
- Reset mid-period: legs drop immediately (asynchronously). After reset_n deasserts, the block resumes via IDLE -> DEAD -> RUN.

Optional Feature:
- Macro: PWM_SLEW_LIMIT_EN.
- Defined:
  - A signed register "applied" (reset 0) is updated at each sample point: applied += clamp(target - applied, -SLEW_STEP, +SLEW_STEP).
  - target is i_command saturated to ±PERIOD.
  - o_duty/o_dir are derived from applied (dir held when applied==0).
  - Reversals therefore ramp through zero; dead time still applies when sign(applied) flips.
  - On IDLE, applied resets to 0.
- Not defined: target is applied directly as described above; the SLEW_STEP parameter is unused.

Test Plan (PERIOD=100, DEADTIME=4, SLEW_STEP=10):
1. Reset, i_enable=1, i_command=+40 -> 4 DEAD cycles with both legs low, then o_pwm_a high exactly 40 of every 100 cycles; o_pwm_b=0; o_period_start every 100 cycles.
2. RUN at +40, change i_command to -70 mid-period -> current period finishes at 40; then 4 cycles with both legs low; then o_pwm_b high 70/100, o_dir=1; a&b never both 1.
3. i_command=+5000, then -2^31 -> o_duty=100, active leg continuously high; no wrap; dir=1 after the 4-cycle dead time.
4. RUN at -30, then i_command=0 -> duty 0, o_dir stays 1, no dead time, legs low, period length 100.
5. Drop i_enable mid-high-phase -> legs low on the next edge, o_active=0. Assert reset_n=0 asynchronously between edges -> all outputs 0 immediately.
6. With PWM_SLEW_LIMIT_EN defined, step i_command 0 -> +35 -> duty sequence 10, 20, 30, 35 over successive periods.
